// File: rtl/ser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ser_pkg                                                              |
// | Shared types and helpers for the serial bit feeder.                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int C_W_MIN = 2;
  localparam int C_W_MAX = 32;

  function automatic bit params_legal(input int w, input int msb_first, input int idle_level);
    return (w >= C_W_MIN) && (w <= C_W_MAX) &&
           (msb_first == 0 || msb_first == 1) &&
           (idle_level == 0 || idle_level == 1);
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_hold_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ser_hold_reg                                                         |
// | One-word prefetch holding register with occupancy flag.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ser_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         hold_v
);

  logic [W-1:0] r_q;
  logic         r_v;

  // load and take are mutually exclusive: a word is only accepted while empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
      r_v <= 1'b0;
    end else if (load) begin
      r_q <= d;
      r_v <= 1'b1;
    end else if (take) begin
      r_v <= 1'b0;
    end
  end

  assign q      = r_q;
  assign hold_v = r_v;

endmodule
`default_nettype wire

// File: rtl/serial_bit_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_bit_feeder                                                    |
// | Parallel-to-serial feeder for the 1010 detector; optional one-word   |
// | prefetch enabled by defining SER_PREFETCH_EN.                        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module serial_bit_feeder #(
  parameter int W          = 8,
  parameter int MSB_FIRST  = 1,
  parameter int IDLE_LEVEL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         bit_en,
  output logic         x,
  output logic         x_valid,
  output logic         word_done,
  output logic         busy
);

  import ser_pkg::*;

  localparam int             C_CW   = cnt_w(W);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(W - 1);
  localparam logic           C_IDLE = (IDLE_LEVEL != 0);

  generate
    if (!params_legal(W, MSB_FIRST, IDLE_LEVEL)) begin : g_bad_params
      $error("serial_bit_feeder: illegal parameter set");
    end
  endgenerate

  state_t          r_state;
  logic [C_CW-1:0] r_cnt;
  logic [W-1:0]    r_shift;

  logic         w_xfer;
  logic         w_is_last;
  logic         w_end;
  logic         w_in_ready;
  logic         w_hold_v;
  logic [W-1:0] w_hold_q;
  logic [W-1:0] w_shift_next;
  logic         w_out_bit;

  assign w_xfer    = in_valid && w_in_ready;
  assign w_is_last = (r_state == SHIFT) && (r_cnt == C_LAST);
  assign w_end     = w_is_last && bit_en;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_out_bit    = r_shift[W-1];
      assign w_shift_next = {r_shift[W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit    = r_shift[0];
      assign w_shift_next = {1'b0, r_shift[W-1:1]};
    end
  endgenerate

`ifdef SER_PREFETCH_EN
  logic w_hold_load;
  logic w_hold_take;

  // A word arriving on the last-bit edge bypasses the holder when it is empty
  assign w_in_ready  = !w_hold_v;
  assign w_hold_load = w_xfer && (r_state == SHIFT) && !w_end;
  assign w_hold_take = w_end && w_hold_v;

  ser_hold_reg #(
    .W (W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load   (w_hold_load),
    .take   (w_hold_take),
    .d      (in_data),
    .q      (w_hold_q),
    .hold_v (w_hold_v)
  );
`else
  assign w_in_ready = (r_state == IDLE);
  assign w_hold_v   = 1'b0;
  assign w_hold_q   = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_shift <= in_data;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            if (r_cnt == C_LAST) begin
              r_cnt <= '0;
              if (w_hold_v) begin
                r_shift <= w_hold_q;
              end else if (w_xfer) begin
                r_shift <= in_data;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_shift <= w_shift_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign x         = (r_state == SHIFT) ? w_out_bit : C_IDLE;
  assign x_valid   = (r_state == SHIFT);
  assign word_done = w_is_last;
  assign busy      = (r_state == SHIFT) || w_hold_v;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_bit_feeder                                                 |
// | Directed self-checking bench; three feeder instances (4b MSB/LSB, 8b)|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_serial_bit_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 4-bit MSB-first instance
  logic [3:0] dm = '0;
  logic vm = 1'b0, em = 1'b1;
  logic rdy_m, x_m, xv_m, wd_m, bz_m;
  // 4-bit LSB-first instance
  logic [3:0] dl = '0;
  logic vl = 1'b0, el = 1'b1;
  logic rdy_l, x_l, xv_l, wd_l, bz_l;
  // 8-bit MSB-first instance
  logic [7:0] db = '0;
  logic vb = 1'b0, eb = 1'b1;
  logic rdy_b, x_b, xv_b, wd_b, bz_b;

  serial_bit_feeder #(.W(4), .MSB_FIRST(1), .IDLE_LEVEL(0)) u_m (
    .clk(clk), .rst(rst), .in_data(dm), .in_valid(vm), .in_ready(rdy_m),
    .bit_en(em), .x(x_m), .x_valid(xv_m), .word_done(wd_m), .busy(bz_m));

  serial_bit_feeder #(.W(4), .MSB_FIRST(0), .IDLE_LEVEL(0)) u_l (
    .clk(clk), .rst(rst), .in_data(dl), .in_valid(vl), .in_ready(rdy_l),
    .bit_en(el), .x(x_l), .x_valid(xv_l), .word_done(wd_l), .busy(bz_l));

  serial_bit_feeder #(.W(8), .MSB_FIRST(1), .IDLE_LEVEL(0)) u_b (
    .clk(clk), .rst(rst), .in_data(db), .in_valid(vb), .in_ready(rdy_b),
    .bit_en(eb), .x(x_b), .x_valid(xv_b), .word_done(wd_b), .busy(bz_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] w4;
    logic [7:0] w8;
    logic       ev, ewd, erdy;
    int         idx;
    int         acc2;

    // Reset state
    tick();
    tick();
    chk("rst_rdy", rdy_m, 1);
    chk("rst_x", x_m, 0);
    chk("rst_xv", xv_m, 0);
    chk("rst_wd", wd_m, 0);
    chk("rst_busy", bz_b, 0);
    rst = 1'b1;
    tick();

    // MSB-first 4'hA -> 1,0,1,0
    w4 = 4'hA;
    dm = w4; vm = 1'b1;
    tick();
    vm = 1'b0;
`ifdef SER_PREFETCH_EN
    chk("msb_rdy_shift", rdy_m, 1);
`else
    chk("msb_rdy_shift", rdy_m, 0);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("msb_x", x_m, w4[3-i]);
      chk("msb_xv", xv_m, 1);
      chk("msb_wd", wd_m, (i == 3));
      tick();
    end
    chk("msb_after_xv", xv_m, 0);
    chk("msb_after_x", x_m, 0);
    chk("msb_after_busy", bz_m, 0);

    // LSB-first 4'h5 -> 1,0,1,0 then 4'hA -> 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      w4 = (k == 0) ? 4'h5 : 4'hA;
      dl = w4; vl = 1'b1;
      tick();
      vl = 1'b0;
      for (int i = 0; i < 4; i++) begin
        chk("lsb_x", x_l, w4[i]);
        chk("lsb_wd", wd_l, (i == 3));
        tick();
      end
      chk("lsb_after_xv", xv_l, 0);
    end

    // Stall: 8'hC3, bit_en low for 3 cycles after 2nd bit, and at last bit
    w8 = 8'hC3;
    db = w8; vb = 1'b1;
    tick();
    vb = 1'b0;
    chk("stall_b0", x_b, w8[7]);
    tick();
    chk("stall_b1", x_b, w8[6]);
    eb = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_hold_x", x_b, w8[6]);
      chk("stall_hold_xv", xv_b, 1);
      chk("stall_hold_wd", wd_b, 0);
    end
    eb = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick();
      chk("stall_x", x_b, w8[7-i]);
      chk("stall_wd", wd_b, (i == 7));
    end
    eb = 1'b0;
    tick();
    chk("stall_last_wd", wd_b, 1);
    chk("stall_last_x", x_b, w8[0]);
    eb = 1'b1;
    tick();
    chk("stall_end_xv", xv_b, 0);
    chk("stall_end_wd", wd_b, 0);

    // Reset mid-word
    db = 8'hFF; vb = 1'b1;
    tick();
    vb = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_x", x_b, 0);
    chk("midrst_xv", xv_b, 0);
    chk("midrst_busy", bz_b, 0);
    chk("midrst_wd", wd_b, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("postrst_rdy", rdy_b, 1);
    chk("postrst_xv", xv_b, 0);
    chk("postrst_x", x_b, 0);

    // Back-to-back 8'h0A, 8'h0A with in_valid held
    w8 = 8'h0A;
    db = w8; vb = 1'b1;
`ifdef SER_PREFETCH_EN
    acc2 = 1;
`else
    acc2 = 9;
`endif
    for (int c = 0; c < 18; c++) begin
      tick();
      if (c == acc2) vb = 1'b0;
`ifdef SER_PREFETCH_EN
      ev   = (c < 16);
      idx  = c % 8;
      erdy = (c == 0) || (c >= 8);
      ewd  = (c == 7) || (c == 15);
`else
      ev   = (c != 8) && (c != 17);
      idx  = (c < 8) ? c : c - 9;
      erdy = !ev;
      ewd  = (c == 7) || (c == 16);
`endif
      chk("b2b_xv", xv_b, ev);
      chk("b2b_x", x_b, ev ? w8[7-idx] : 1'b0);
      chk("b2b_rdy", rdy_b, erdy);
      chk("b2b_wd", wd_b, ewd);
    end

    // New word offered on the last-bit edge with nothing held
    dm = 4'hA; vm = 1'b1;
    tick();
    vm = 1'b0;
    tick();
    tick();
    tick();
    chk("bnd_last_wd", wd_m, 1);
    dm = 4'h5; vm = 1'b1;
    tick();
`ifdef SER_PREFETCH_EN
    vm = 1'b0;
    chk("bnd_nogap_xv", xv_m, 1);
`else
    chk("bnd_gap_xv", xv_m, 0);
    chk("bnd_gap_rdy", rdy_m, 1);
    tick();
    vm = 1'b0;
    chk("bnd_xv", xv_m, 1);
`endif
    chk("bnd_b0", x_m, 0);
    tick();
    chk("bnd_b1", x_m, 1);
    tick();
    tick();
    chk("bnd_b3", x_m, 1);
    chk("bnd_b3_wd", wd_m, 1);
    tick();
    chk("bnd_end_xv", xv_m, 0);

    // Reset while a second word is pending (held in the prefetch build)
    db = 8'h0A; vb = 1'b1;
    tick();
    tick();
    vb = 1'b0;
    chk("hrst_busy_pre", bz_b, 1);
`ifdef SER_PREFETCH_EN
    chk("hrst_rdy_pre", rdy_b, 0);
`endif
    rst = 1'b0;
    #1;
    chk("hrst_busy", bz_b, 0);
    chk("hrst_rdy", rdy_b, 1);
    tick();
    rst = 1'b1;
    for (int s = 0; s < 10; s++) begin
      tick();
      chk("hrst_noreplay_xv", xv_b, 0);
    end
    chk("hrst_final_busy", bz_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
